// File: rtl/alu_issue_stage.sv
// ID/EX issue register: decodes a MIPS instruction into ALU op/operands plus wb/mem/branch controls.
// Optional macro ALU_ISSUE_LUI_EN enables lui decode; otherwise opcode 0x0F is treated as illegal.
module alu_issue_stage #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             stall,
    input  logic             flush,
    input  logic [31:0]      instr,
    input  logic [31:0]      rs_data,
    input  logic [31:0]      rt_data,
    output logic             out_valid,
    output logic [2:0]       alucont,
    output logic [31:0]      src_a,
    output logic [31:0]      src_b,
    output logic             reg_write,
    output logic [4:0]       wb_reg,
    output logic             mem_read,
    output logic             mem_write,
    output logic [31:0]      store_data,
    output logic             branch_eq,
    output logic             branch_ne,
    output logic             illegal,
    output logic [CNT_W-1:0] illegal_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [5:0]  opcode, funct;
    logic [31:0] imm_sext, imm_zext;

    logic [2:0]  dec_alucont;
    logic [31:0] dec_src_a, dec_src_b;
    logic [4:0]  dec_wb_reg;
    logic        dec_reg_write, dec_mem_read, dec_mem_write;
    logic        dec_beq, dec_bne, dec_illegal;

    logic             out_valid_q, out_valid_d;
    logic [2:0]       alucont_q, alucont_d;
    logic [31:0]      src_a_q, src_a_d, src_b_q, src_b_d, store_data_q, store_data_d;
    logic [4:0]       wb_reg_q, wb_reg_d;
    logic             reg_write_q, reg_write_d, mem_read_q, mem_read_d;
    logic             mem_write_q, mem_write_d, branch_eq_q, branch_eq_d;
    logic             branch_ne_q, branch_ne_d, illegal_q, illegal_d;
    logic [CNT_W-1:0] illegal_count_q, illegal_count_d;

    assign opcode   = instr[31:26];
    assign funct    = instr[5:0];
    assign imm_sext = {{16{instr[15]}}, instr[15:0]};
    assign imm_zext = {16'b0, instr[15:0]};

    always_comb begin
        dec_alucont   = 3'b010;
        dec_src_a     = rs_data;
        dec_src_b     = rt_data;
        dec_wb_reg    = instr[20:16];
        dec_reg_write = 1'b0;
        dec_mem_read  = 1'b0;
        dec_mem_write = 1'b0;
        dec_beq       = 1'b0;
        dec_bne       = 1'b0;
        dec_illegal   = 1'b0;
        case (opcode)
            6'h00: begin
                dec_wb_reg    = instr[15:11];
                dec_reg_write = 1'b1;
                case (funct)
                    6'h20, 6'h21: dec_alucont = 3'b010;
                    6'h22, 6'h23: dec_alucont = 3'b110;
                    6'h24:        dec_alucont = 3'b000;
                    6'h25:        dec_alucont = 3'b001;
                    6'h2A:        dec_alucont = 3'b111;
                    6'h00: begin dec_alucont = 3'b011; dec_src_a = {27'b0, instr[10:6]}; end
                    6'h02: begin dec_alucont = 3'b101; dec_src_a = {27'b0, instr[10:6]}; end
                    6'h03: begin dec_alucont = 3'b100; dec_src_a = {27'b0, instr[10:6]}; end
                    6'h04: begin dec_alucont = 3'b011; dec_src_a = {27'b0, rs_data[4:0]}; end
                    6'h06: begin dec_alucont = 3'b101; dec_src_a = {27'b0, rs_data[4:0]}; end
                    6'h07: begin dec_alucont = 3'b100; dec_src_a = {27'b0, rs_data[4:0]}; end
                    default: dec_illegal = 1'b1;
                endcase
            end
            6'h08, 6'h09: begin dec_src_b = imm_sext; dec_reg_write = 1'b1; end
            6'h0A: begin dec_alucont = 3'b111; dec_src_b = imm_sext; dec_reg_write = 1'b1; end
            6'h23: begin dec_src_b = imm_sext; dec_reg_write = 1'b1; dec_mem_read = 1'b1; end
            6'h2B: begin dec_src_b = imm_sext; dec_mem_write = 1'b1; end
            6'h0C: begin dec_alucont = 3'b000; dec_src_b = imm_zext; dec_reg_write = 1'b1; end
            6'h0D: begin dec_alucont = 3'b001; dec_src_b = imm_zext; dec_reg_write = 1'b1; end
            6'h04: begin dec_alucont = 3'b110; dec_beq = 1'b1; end
            6'h05: begin dec_alucont = 3'b110; dec_bne = 1'b1; end
`ifdef ALU_ISSUE_LUI_EN
            // lui realised as a 16-bit left shift of the zero-extended immediate
            6'h0F: begin
                dec_alucont   = 3'b011;
                dec_src_a     = 32'd16;
                dec_src_b     = imm_zext;
                dec_reg_write = 1'b1;
            end
`endif
            default: dec_illegal = 1'b1;
        endcase
        if (dec_illegal) begin
            dec_alucont   = 3'b010;
            dec_src_a     = 32'b0;
            dec_src_b     = 32'b0;
            dec_wb_reg    = 5'd0;
            dec_reg_write = 1'b0;
        end
        // $0 is hardwired, so writes to it are dropped (makes nop harmless)
        if (dec_wb_reg == 5'd0) dec_reg_write = 1'b0;
    end

    always_comb begin
        out_valid_d     = out_valid_q;
        alucont_d       = alucont_q;
        src_a_d         = src_a_q;
        src_b_d         = src_b_q;
        wb_reg_d        = wb_reg_q;
        store_data_d    = store_data_q;
        reg_write_d     = reg_write_q;
        mem_read_d      = mem_read_q;
        mem_write_d     = mem_write_q;
        branch_eq_d     = branch_eq_q;
        branch_ne_d     = branch_ne_q;
        illegal_d       = illegal_q;
        illegal_count_d = illegal_count_q;
        if (flush) begin
            out_valid_d = 1'b0;
            reg_write_d = 1'b0;
            mem_read_d  = 1'b0;
            mem_write_d = 1'b0;
            branch_eq_d = 1'b0;
            branch_ne_d = 1'b0;
            illegal_d   = 1'b0;
        end else if (!stall) begin
            out_valid_d  = in_valid;
            alucont_d    = dec_alucont;
            src_a_d      = dec_src_a;
            src_b_d      = dec_src_b;
            wb_reg_d     = dec_wb_reg;
            store_data_d = rt_data;
            reg_write_d  = in_valid & dec_reg_write;
            mem_read_d   = in_valid & dec_mem_read;
            mem_write_d  = in_valid & dec_mem_write;
            branch_eq_d  = in_valid & dec_beq;
            branch_ne_d  = in_valid & dec_bne;
            illegal_d    = in_valid & dec_illegal;
            if (in_valid && dec_illegal && illegal_count_q != CNT_MAX)
                illegal_count_d = illegal_count_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q     <= 1'b0;
            alucont_q       <= 3'b0;
            src_a_q         <= 32'b0;
            src_b_q         <= 32'b0;
            wb_reg_q        <= 5'b0;
            store_data_q    <= 32'b0;
            reg_write_q     <= 1'b0;
            mem_read_q      <= 1'b0;
            mem_write_q     <= 1'b0;
            branch_eq_q     <= 1'b0;
            branch_ne_q     <= 1'b0;
            illegal_q       <= 1'b0;
            illegal_count_q <= '0;
        end else begin
            out_valid_q     <= out_valid_d;
            alucont_q       <= alucont_d;
            src_a_q         <= src_a_d;
            src_b_q         <= src_b_d;
            wb_reg_q        <= wb_reg_d;
            store_data_q    <= store_data_d;
            reg_write_q     <= reg_write_d;
            mem_read_q      <= mem_read_d;
            mem_write_q     <= mem_write_d;
            branch_eq_q     <= branch_eq_d;
            branch_ne_q     <= branch_ne_d;
            illegal_q       <= illegal_d;
            illegal_count_q <= illegal_count_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign alucont       = alucont_q;
    assign src_a         = src_a_q;
    assign src_b         = src_b_q;
    assign wb_reg        = wb_reg_q;
    assign store_data    = store_data_q;
    assign reg_write     = reg_write_q;
    assign mem_read      = mem_read_q;
    assign mem_write     = mem_write_q;
    assign branch_eq     = branch_eq_q;
    assign branch_ne     = branch_ne_q;
    assign illegal       = illegal_q;
    assign illegal_count = illegal_count_q;

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Registered ID/EX issue stage that drives the EX-stage ALU.
- Decodes the 32-bit MIPS instruction into the ALU's 3-bit op code (alucont) and builds the two 32-bit operands (a, b).
- Also produces the writeback/memory/branch control bits that travel alongside the ALU result.
- Sits between the register file read and the ALU; honours pipeline stall and flush.

Parameters:
- CNT_W, 16, width of the saturating illegal-instruction counter.

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  instr/rs_data/rt_data valid this cycle
- stall  input  1  hold all outputs; ignore inputs
- flush  input  1  squash: next out_valid=0
- instr  input  32  instruction word
- rs_data  input  32  register rs value
- rt_data  input  32  register rt value
- out_valid  output  1  issue-register contents valid
- alucont  output  3  ALU op: 000 and, 001 or, 010 add, 011 shl (b<<a), 100 sra (b>>>a), 101 srl (b>>a), 110 sub (a-b), 111 slt signed
- src_a  output  32  ALU a operand
- src_b  output  32  ALU b operand
- reg_write  output  1  write result to register file
- wb_reg  output  5  destination register
- mem_read  output  1  load
- mem_write  output  1  store
- store_data  output  32  rt_data for sw
- branch_eq  output  1  beq: taken when ALU zero=1
- branch_ne  output  1  bne: taken when ALU zero=0
- illegal  output  1  unsupported instruction issued
- illegal_count  output  CNT_W  saturating count of issued illegal instructions

Behaviour:
- Reset (async, rst_n=0): all outputs 0, illegal_count=0.
- Latency: 1 cycle, input to registered outputs.
- Per rising edge, in priority order:
  - flush=1: out_valid<=0 and all control bits (reg_write, mem_*, branch_*, illegal) <=0; data fields don't-care. Flush wins over stall.
  - Else stall=1: every register holds, including illegal_count.
  - Else: out_valid<=in_valid, decoded fields loaded. When in_valid=0, control bits <=0.
- R-type (opcode 0x00): src_a=rs_data, src_b=rt_data, wb_reg=rd, reg_write=1.
  - funct 0x20 add, 0x21 addu -> 010
  - funct 0x22 sub, 0x23 subu -> 110
  - funct 0x24 -> 000; 0x25 -> 001; 0x2A -> 111
  - Shifts: 0x00 sll->011, 0x02 srl->101, 0x03 sra->100 use src_a={27'b0,shamt}, src_b=rt_data.
  - Variable shifts: 0x04 sllv, 0x06 srlv, 0x07 srav use src_a={27'b0,rs_data[4:0]}.
- I-type: src_a=rs_data, wb_reg=rt.
  - Sign-extended imm16: addi 0x08, addiu 0x09 ->010; slti 0x0A ->111; lw 0x23 ->010 + mem_read; sw 0x2B ->010 + mem_write, reg_write=0.
  - Zero-extended imm16: andi 0x0C ->000; ori 0x0D ->001.
  - beq 0x04 / bne 0x05: src_b=rt_data, alucont 110, reg_write=0, branch_eq/branch_ne=1.
- reg_write is forced 0 when wb_reg==0 (nop 0x00000000 issues harmlessly).
- store_data=rt_data always.
- Any other opcode/funct:
  - illegal=1, alucont=010, src_a=src_b=0, all other control 0, out_valid follows in_valid.
  - illegal_count increments once per issued illegal instruction and saturates at all-ones.
  - A stalled or flushed illegal instruction is not counted.
- Reset asserted mid-stall or mid-flush: immediate clear; first capture is the first non-stalled edge after rst_n rises.

Optional Feature:
- Macro ALU_ISSUE_LUI_EN.
- Defined: lui (opcode 0x0F) decodes to alucont 011, src_a=32'd16, src_b=zero-extended imm16, wb_reg=rt, reg_write=1.
- Undefined: opcode 0x0F is illegal (illegal=1, counted).

Test Plan:
- 0x00221820 (add $3,$1,$2), rs=5, rt=7, in_valid=1 -> next cycle: out_valid=1, alucont=010, src_a=5, src_b=7, wb_reg=3, reg_write=1.
- 0x00022103 (sra $4,$2,4), rt=0x80000000 -> alucont=100, src_a=4, src_b=0x80000000. 0x2025FFFF (addi $5,$1,-1) -> src_b=0xFFFFFFFF. 0x34268000 (ori) -> src_b=0x00008000, alucont=001.
- 0xAC220004 (sw) -> mem_write=1, reg_write=0, src_b=4, store_data=rt. 0x10220003 (beq) -> branch_eq=1, alucont=110, src_b=rt.
- Issue add, then stall=1 for 3 cycles with new instr -> outputs unchanged. flush=1 together with stall=1 -> out_valid=0, reg_write=0.
- 0x3C071234 (lui): with macro -> alucont=011, src_a=16, src_b=0x1234, wb_reg=7. Without macro -> illegal=1, illegal_count 0->1. With CNT_W=2, 5 illegals -> count saturates at 3.
- rst_n low mid-stream -> all outputs 0 immediately, without a clock edge.
